// File: rtl/conv_window_gen.sv
// 3x3 sliding-window generator for a padded raster pixel stream.
// Two line memories supply the two previous rows; a 3x3 register array forms the window.
module conv_window_gen #(
  parameter int DATA_W  = 64,
  parameter int MAX_COL = 418
) (
  input  logic                  sclk,
  input  logic                  s_rst_n,
  input  logic [2:0]            feature_col_select,
  input  logic                  stride_sel,
  input  logic [DATA_W-1:0]     padding_data,
  input  logic                  padding_data_vld,
  input  logic                  padding_finish,
  input  logic [6:0]            row_cnt,
  input  logic [8:0]            col_cnt,
  output logic [9*DATA_W-1:0]   win_data,
  output logic                  win_vld,
  output logic [6:0]            win_row,
  output logic [8:0]            win_col,
  output logic                  win_finish
);

  localparam int         AW        = $clog2(MAX_COL);
  localparam logic [9:0] MAX_COL_L = 10'(MAX_COL);

  logic [8:0]            row_width;
  logic                  in_range;
  logic [AW-1:0]         addr;
  logic [DATA_W-1:0]     line1 [MAX_COL];
  logic [DATA_W-1:0]     line2 [MAX_COL];
  logic [DATA_W-1:0]     l1_rd;
  logic [DATA_W-1:0]     l2_rd;

  logic                  s1_vld;
  logic                  s1_ok;
  logic                  s1_fin;
  logic [6:0]            s1_row;
  logic [8:0]            s1_col;
  logic [3*DATA_W-1:0]   s1_column;

  logic                  hit;
  logic [6:0]            row_off;
  logic [8:0]            col_off;
  logic [9*DATA_W-1:0]   win_shift;

  always_comb begin
    case (feature_col_select)
      3'd0:    row_width = 9'd418;
      3'd1:    row_width = 9'd210;
      3'd2:    row_width = 9'd106;
      3'd3:    row_width = 9'd54;
      3'd4:    row_width = 9'd28;
      3'd5:    row_width = 9'd15;
      default: row_width = 9'd418;
    endcase
  end

  // Columns beyond the selected width (or the memory depth) are never stored or windowed.
  assign in_range = (col_cnt < row_width) && ({1'b0, col_cnt} < MAX_COL_L);
  assign addr     = AW'(col_cnt);

  always_comb begin
    l1_rd = '0;
    l2_rd = '0;
    if (in_range) begin
      l1_rd = line1[addr];
      l2_rd = line2[addr];
    end
  end

  // Read-before-write: the old L1 word cascades into L2 as the new pixel lands in L1.
  always_ff @(posedge sclk) begin
    if (padding_data_vld && in_range) begin
      line1[addr] <= padding_data;
      line2[addr] <= l1_rd;
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      s1_vld    <= 1'b0;
      s1_ok     <= 1'b0;
      s1_fin    <= 1'b0;
      s1_row    <= '0;
      s1_col    <= '0;
      s1_column <= '0;
    end else begin
      s1_vld <= padding_data_vld;
      s1_fin <= padding_finish;
      if (padding_data_vld) begin
        s1_ok     <= in_range;
        s1_row    <= row_cnt;
        s1_col    <= col_cnt;
        s1_column <= {padding_data, l1_rd, l2_rd};
      end
    end
  end

  // The c>=2 gate also hides the two columns straddling each row wrap.
  always_comb begin
    row_off   = s1_row - 7'd2;
    col_off   = s1_col - 9'd2;
    hit       = s1_ok && (s1_row >= 7'd2) && (s1_col >= 9'd2) &&
                (!stride_sel || (!s1_row[0] && !s1_col[0]));
    win_shift = win_data;
    for (int i = 0; i < 3; i++) begin
      win_shift[DATA_W*(3*i)   +: DATA_W] = win_data[DATA_W*(3*i+1) +: DATA_W];
      win_shift[DATA_W*(3*i+1) +: DATA_W] = win_data[DATA_W*(3*i+2) +: DATA_W];
      win_shift[DATA_W*(3*i+2) +: DATA_W] = s1_column[DATA_W*i +: DATA_W];
    end
  end

  always_ff @(posedge sclk or negedge s_rst_n) begin
    if (!s_rst_n) begin
      win_vld    <= 1'b0;
      win_finish <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      win_data   <= '0;
    end else begin
      win_vld    <= s1_vld && hit;
      win_finish <= s1_fin;
      if (s1_vld) begin
        win_data <= win_shift;
      end
      if (s1_vld && hit) begin
        win_row <= stride_sel ? (row_off >> 1) : row_off;
        win_col <= stride_sel ? (col_off >> 1) : col_off;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_gen.sv
// Randomized bench for conv_window_gen against a pixel-grid reference model.
// Expected windows are taken directly from the stored image at the spec'd coordinates.
module tb_conv_window_gen;

  localparam int DW = 64;
  localparam int WW = 9 * DW;

  logic            sclk = 1'b0;
  logic            s_rst_n;
  logic [2:0]      feature_col_select;
  logic            stride_sel;
  logic [DW-1:0]   padding_data;
  logic            padding_data_vld;
  logic            padding_finish;
  logic [6:0]      row_cnt;
  logic [8:0]      col_cnt;
  logic [WW-1:0]   win_data;
  logic            win_vld;
  logic [6:0]      win_row;
  logic [8:0]      win_col;
  logic            win_finish;

  always #5 sclk = ~sclk;

  conv_window_gen #(.DATA_W(DW), .MAX_COL(418)) dut (
    .sclk               (sclk),
    .s_rst_n            (s_rst_n),
    .feature_col_select (feature_col_select),
    .stride_sel         (stride_sel),
    .padding_data       (padding_data),
    .padding_data_vld   (padding_data_vld),
    .padding_finish     (padding_finish),
    .row_cnt            (row_cnt),
    .col_cnt            (col_cnt),
    .win_data           (win_data),
    .win_vld            (win_vld),
    .win_row            (win_row),
    .win_col            (win_col),
    .win_finish         (win_finish)
  );

  typedef struct {
    bit            vld;
    bit            fin;
    logic [6:0]    row;
    logic [8:0]    col;
    logic [WW-1:0] data;
  } exp_t;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] img [128][512];
  exp_t          pend [$];
  int            win_count;
  logic [WW-1:0] first_data;
  logic [WW-1:0] last_data;
  logic [6:0]    last_row;
  logic [8:0]    last_col;

  task automatic checkOutput(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input logic [2:0] sel);
    case (sel)
      3'd1:    return 210;
      3'd2:    return 106;
      3'd3:    return 54;
      3'd4:    return 28;
      3'd5:    return 15;
      default: return 418;
    endcase
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e.vld  = 1'b0;
    e.fin  = 1'b0;
    e.row  = '0;
    e.col  = '0;
    e.data = '0;
    return e;
  endfunction

  // One clock: check the outputs owed for two cycles ago, then drive this cycle's inputs.
  task automatic applyStimulus(input bit vld, input bit fin, input int r, input int c,
                               input logic [DW-1:0] d);
    exp_t e;
    @(posedge sclk);
    #1;
    e = pend.pop_front();
    checkOutput("win_vld", WW'(win_vld), WW'(e.vld));
    checkOutput("win_finish", WW'(win_finish), WW'(e.fin));
    if (e.vld) begin
      checkOutput("win_row", WW'(win_row), WW'(e.row));
      checkOutput("win_col", WW'(win_col), WW'(e.col));
      checkOutput("win_data", win_data, e.data);
    end
    if (win_vld === 1'b1) begin
      if (win_count == 0) first_data = win_data;
      win_count++;
      last_data = win_data;
      last_row  = win_row;
      last_col  = win_col;
    end

    padding_data_vld = vld;
    padding_finish   = fin;
    row_cnt          = 7'(r);
    col_cnt          = 9'(c);
    padding_data     = d;

    e = idle_exp();
    e.fin = fin;
    if (vld) begin
      img[r][c] = d;
      if (c < width_of(feature_col_select) && r >= 2 && c >= 2 &&
          (!stride_sel || (r % 2 == 0 && c % 2 == 0))) begin
        e.vld = 1'b1;
        e.row = stride_sel ? 7'((r - 2) / 2) : 7'(r - 2);
        e.col = stride_sel ? 9'((c - 2) / 2) : 9'(c - 2);
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.data[DW*(3*i+j) +: DW] = img[r-2+i][c-2+j];
      end
    end
    pend.push_back(e);
  endtask

  task automatic do_reset();
    padding_data_vld = 1'b0;
    padding_finish   = 1'b0;
    s_rst_n          = 1'b0;
    #2;
    checkOutput("rst_win_vld", WW'(win_vld), '0);
    checkOutput("rst_win_finish", WW'(win_finish), '0);
    checkOutput("rst_win_row", WW'(win_row), '0);
    checkOutput("rst_win_col", WW'(win_col), '0);
    checkOutput("rst_win_data", win_data, '0);
    @(negedge sclk);
    @(negedge sclk);
    s_rst_n = 1'b1;
    pend.delete();
    pend.push_back(idle_exp());
    pend.push_back(idle_exp());
  endtask

  task automatic run_frame(input int rows, input int cols, input int gap_pct,
                           input bit rand_data, input int fin_at);
    int n = 0;
    logic [DW-1:0] d;
    for (int r = 0; r < rows; r++) begin
      for (int c = 0; c < cols; c++) begin
        while (gap_pct > 0 && $urandom_range(99) < gap_pct)
          applyStimulus(0, 0, int'($urandom_range(127)), int'($urandom_range(511)), {$urandom, $urandom});
        d = rand_data ? {$urandom, $urandom} : DW'({7'(r), 9'(c)});
        applyStimulus(1, n == fin_at, r, c, d);
        n++;
      end
    end
    repeat (3) applyStimulus(0, 0, 0, 0, '0);
  endtask

  initial begin
    feature_col_select = 3'd5;
    stride_sel         = 1'b0;
    padding_data       = '0;
    padding_data_vld   = 1'b0;
    padding_finish     = 1'b0;
    row_cnt            = '0;
    col_cnt            = '0;
    do_reset();

    // Basic stride-1 windowing on a 4x15 frame with coordinate-valued pixels.
    win_count = 0;
    run_frame(4, 15, 0, 0, -1);
    checkOutput("basic_count", WW'(win_count), WW'(26));
    checkOutput("basic_tap00", WW'(first_data[0 +: DW]), '0);
    checkOutput("basic_tap22", WW'(first_data[DW*8 +: DW]), WW'({7'd2, 9'd2}));
    checkOutput("basic_last_row", WW'(last_row), WW'(1));
    checkOutput("basic_last_col", WW'(last_col), WW'(12));

    // Stride 2 on the same frame.
    stride_sel = 1'b1;
    win_count  = 0;
    run_frame(4, 15, 0, 0, -1);
    checkOutput("stride2_count", WW'(win_count), WW'(7));
    checkOutput("stride2_last_row", WW'(last_row), WW'(0));
    checkOutput("stride2_last_col", WW'(last_col), WW'(6));
    checkOutput("stride2_last_tap00", WW'(last_data[0 +: DW]), WW'({7'd0, 9'd12}));
    stride_sel = 1'b0;

    // Random gaps, random data, finish coincident with a pixel, columns past the width.
    win_count = 0;
    run_frame(4, 17, 30, 1, 40);
    checkOutput("gap_count", WW'(win_count), WW'(26));

    // Standalone finish pulse.
    applyStimulus(0, 1, 0, 0, '0);
    repeat (4) applyStimulus(0, 0, 0, 0, '0);

    // Other widths with random data.
    for (int s = 1; s <= 4; s++) begin
      feature_col_select = 3'(s);
      win_count = 0;
      run_frame(3, width_of(3'(s)), 10, 1, -1);
      checkOutput("width_count", WW'(win_count), WW'(width_of(3'(s)) - 2));
    end

    // Reset in the middle of row 2, then a fresh batch.
    feature_col_select = 3'd4;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 28 && !(r == 2 && c == 10); c++)
        applyStimulus(1, 0, r, c, {$urandom, $urandom});
    do_reset();
    win_count = 0;
    run_frame(4, 28, 10, 1, -1);
    checkOutput("reset_count", WW'(win_count), WW'(52));

    // Full width: 418 columns, no address wrap at column 417.
    feature_col_select = 3'd0;
    win_count = 0;
    run_frame(3, 418, 0, 1, -1);
    checkOutput("full_count", WW'(win_count), WW'(416));
    checkOutput("full_last_col", WW'(last_col), WW'(415));
    checkOutput("full_tap22", WW'(last_data[DW*8 +: DW]), WW'(img[2][417]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_window_gen.md
CONV_WINDOW_GEN -- requirements
Module: conv_window_gen

Interface
REQ-001 SHALL have parameter DATA_W, default 64, meaning pixel word width (8 channels x 8 bit).
REQ-002 SHALL have parameter MAX_COL, default 418, meaning line-memory depth (widest padded row).
REQ-003 SHALL have port sclk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port s_rst_n, input, 1, meaning reset, asynchronous and active-low.
REQ-005 SHALL have port feature_col_select, input, 3, meaning padded row width: 0:418, 1:210, 2:106, 3:54, 4:28, 5:15, other:418.
REQ-006 SHALL have port stride_sel, input, 1, meaning 0 = stride 1, 1 = stride 2; held static per layer.
REQ-007 SHALL have port padding_data, input, DATA_W, meaning the padded pixel stream from the upstream padding stage.
REQ-008 SHALL have port padding_data_vld, input, 1, meaning padding_data, row_cnt and col_cnt are valid this cycle.
REQ-009 SHALL have port padding_finish, input, 1, meaning a single-cycle end-of-batch pulse.
REQ-010 SHALL have port row_cnt, input, 7, meaning the padded row index of the current pixel.
REQ-011 SHALL have port col_cnt, input, 9, meaning the padded column index of the current pixel.
REQ-012 SHALL have port win_data, output, 9*DATA_W, meaning the 3x3 window, with tap (i,j) at bits [DATA_W*(3i+j) +: DATA_W] and i = row, j = col, 0 = oldest.
REQ-013 SHALL have port win_vld, output, 1, meaning win_data, win_row and win_col are valid.
REQ-014 SHALL have port win_row, output, 7, meaning the output-feature row index.
REQ-015 SHALL have port win_col, output, 9, meaning the output-feature column index.
REQ-016 SHALL have port win_finish, output, 1, meaning a single-cycle end-of-batch pulse.

Function
REQ-017 SHALL hold two line memories, L1 (previous row) and L2 (row before that), each MAX_COL x DATA_W, addressed by col_cnt.
REQ-018 SHALL, on each cycle with padding_data_vld=1, read L1[col_cnt] and L2[col_cnt] read-before-write, then write L1[col_cnt] <= padding_data and L2[col_cnt] <= old L1[col_cnt].
REQ-019 SHALL, in stage 1, register {L2 rd, L1 rd, padding_data} as a column vector, plus the valid, row and column.
REQ-020 SHALL, in stage 2, shift that column into a 3x3 register array: column 2 <= new, column 1 <= column 2, column 0 <= column 1.
REQ-021 SHALL, for input accepted in cycle T with row r and column c, drive the outputs in cycle T+2 (latency 2).
REQ-022 SHALL, in that cycle, set win_vld=1 iff r>=2 and c>=2, and for stride_sel=1 additionally require r[0]=0 and c[0]=0.
REQ-023 SHALL, when win_vld=1, set win_row = r-2 and win_col = c-2 for stride 1, and win_row = (r-2)>>1 and win_col = (c-2)>>1 for stride 2.
REQ-024 SHALL make window tap (i,j) equal the input pixel at (r-2+i, c-2+j).
REQ-025 SHALL advance the pipeline only on valid input; when padding_data_vld=0, it SHALL hold the window registers and drive win_vld=0 on the next output cycle.
REQ-026 SHALL never emit a window spanning the row boundary, since c>=2 gating guarantees this at every row wrap.
REQ-027 SHALL emit win_finish exactly 2 cycles after padding_finish.
REQ-028 SHALL, if padding_finish and padding_data_vld are both asserted in one cycle, process both normally.
REQ-029 SHALL not require clearing the line memories between layers or batches, because rows 0-1 overwrite every location before any use.
REQ-030 SHALL use col_cnt >= the selected width as an out-of-range address, suppressing the write and forcing win_vld=0 for that pixel.

Reset
REQ-031 SHALL, while s_rst_n=0, asynchronously clear win_vld, win_finish, win_row, win_col, win_data and all pipeline valid, row and column registers to 0.
REQ-032 SHALL leave line-memory contents undefined after reset, and SHALL not use them before they are rewritten (per REQ-029).
REQ-033 SHALL, on reset mid-frame, drop any in-flight window, and the next batch SHALL start cleanly from row_cnt=0.

Verification
REQ-034 SHALL verify basic windowing: select=5, stride 1, 4 rows x 15 cols, pixel = {row,col} -> first win_vld 2 cycles after (r=2,c=2), taps (0,0)={0,0} and (2,2)={2,2}, 26 windows total, last at win_row=1, win_col=12.
REQ-035 SHALL verify stride 2: same stimulus with stride_sel=1 -> 7 windows, all with win_row=0, win_col=0..6, tap (0,0)={0,2*win_col}.
REQ-036 SHALL verify gaps: random padding_data_vld deasserts mid-row -> the window sequence matches the gap-free run, with win_vld only at T+2 of accepted pixels.
REQ-037 SHALL verify finish timing: padding_finish pulse in cycle T -> win_finish=1 in T+2 only.
REQ-038 SHALL verify reset: s_rst_n low mid-row 2, then a fresh 4-row batch -> no window before the new (r=2,c=2), and all taps correct.
REQ-039 SHALL verify full width: select=0 (418 cols), 3 rows -> 416 windows, and the tap at col 417 reads correctly (no address wrap).
